// File: rtl/ac_pkg.sv
// Shared types and constants for the Aho-Corasick stream matcher.
// Entry typedefs are sized by AC_STATE_W / AC_PAT_W, which the top's STATE_W / PAT_W default to.
package ac_pkg;

   localparam int AC_STATE_W = 6;
   localparam int AC_PAT_W   = 4;

   localparam logic [1:0] SEL_GOTO = 2'd0;
   localparam logic [1:0] SEL_FAIL = 2'd1;
   localparam logic [1:0] SEL_OUT  = 2'd2;
   localparam logic [1:0] SEL_DICT = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_FAIL,
      S_REPORT,
      S_DONE
   } fsm_t;

   typedef struct packed {
      logic                  hit;
      logic [AC_STATE_W-1:0] next;
   } goto_entry_t;

   typedef struct packed {
      logic                valid;
      logic [AC_PAT_W-1:0] id;
   } out_entry_t;

endpackage

// File: rtl/ac_table_ram.sv
// Generic register-array table: synchronous write, asynchronous read, no reset.
module ac_table_ram #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ac_stream_matcher.sv
// Streaming Aho-Corasick matcher with run-time loaded goto/fail/output tables.
// Build option: define AC_DICT_LINK_EN to add the dictionary-link table and the S_REPORT walk.
module ac_stream_matcher
   import ac_pkg::*;
#(
   parameter int CHAR_W  = 8,
   parameter int STATE_W = AC_STATE_W,
   parameter int PAT_W   = AC_PAT_W,
   parameter int POS_W   = 16
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      EN,
   input  logic                      CFG_WE,
   input  logic [1:0]                CFG_SEL,
   input  logic [STATE_W+CHAR_W-1:0] CFG_ADDR,
   input  logic [STATE_W+PAT_W:0]    CFG_DATA,
   input  logic                      IN_VALID,
   output logic                      IN_READY,
   input  logic [CHAR_W-1:0]         IN_CHAR,
   input  logic                      IN_LAST,
   output logic                      MATCH_VALID,
   output logic [PAT_W-1:0]          MATCH_ID,
   output logic [POS_W-1:0]          MATCH_POS,
   output logic                      DONE
);

   fsm_t               r_fsm;
   logic [STATE_W-1:0] r_cur;
   logic [STATE_W-1:0] r_dptr;
   logic [CHAR_W-1:0]  r_char;
   logic               r_last;
   logic [POS_W-1:0]   r_pos;
   logic               r_mvalid;
   logic [PAT_W-1:0]   r_mid;
   logic [POS_W-1:0]   r_mpos;
   logic               r_done;

   logic               w_cfg_ok;
   logic [CHAR_W-1:0]  w_char;
   goto_entry_t        w_g;
   logic [STATE_W-1:0] w_fail_next;
   logic [STATE_W-1:0] w_out_addr;
   out_entry_t         w_out;
   logic               w_dict_valid;
   logic [STATE_W-1:0] w_dict_state;
   logic               w_last_now;
   fsm_t               w_after;
   logic               w_unused;

   assign w_cfg_ok   = CFG_WE && !EN;
   assign w_char     = (r_fsm == S_ACCEPT) ? IN_CHAR : r_char;
   assign w_out_addr = (r_fsm == S_REPORT) ? r_dptr : w_g.next;
   assign w_last_now = (r_fsm == S_ACCEPT) ? IN_LAST : r_last;
   assign w_after    = w_last_now ? S_DONE : (EN ? S_ACCEPT : S_IDLE);
   assign w_unused   = ^CFG_DATA[STATE_W+PAT_W:STATE_W+1];

   ac_table_ram #(.ADDR_W(STATE_W+CHAR_W), .DATA_W(STATE_W+1)) u_goto (
      .i_clk   (CLK),
      .i_we    (w_cfg_ok && (CFG_SEL == SEL_GOTO)),
      .i_waddr (CFG_ADDR),
      .i_wdata (CFG_DATA[STATE_W:0]),
      .i_raddr ({r_cur, w_char}),
      .o_rdata (w_g)
   );

   ac_table_ram #(.ADDR_W(STATE_W), .DATA_W(STATE_W)) u_fail (
      .i_clk   (CLK),
      .i_we    (w_cfg_ok && (CFG_SEL == SEL_FAIL)),
      .i_waddr (CFG_ADDR[STATE_W-1:0]),
      .i_wdata (CFG_DATA[STATE_W-1:0]),
      .i_raddr (r_cur),
      .o_rdata (w_fail_next)
   );

   ac_table_ram #(.ADDR_W(STATE_W), .DATA_W(PAT_W+1)) u_out (
      .i_clk   (CLK),
      .i_we    (w_cfg_ok && (CFG_SEL == SEL_OUT)),
      .i_waddr (CFG_ADDR[STATE_W-1:0]),
      .i_wdata (CFG_DATA[PAT_W:0]),
      .i_raddr (w_out_addr),
      .o_rdata (w_out)
   );

`ifdef AC_DICT_LINK_EN
   logic [STATE_W:0] w_dict_raw;

   ac_table_ram #(.ADDR_W(STATE_W), .DATA_W(STATE_W+1)) u_dict (
      .i_clk   (CLK),
      .i_we    (w_cfg_ok && (CFG_SEL == SEL_DICT)),
      .i_waddr (CFG_ADDR[STATE_W-1:0]),
      .i_wdata (CFG_DATA[STATE_W:0]),
      .i_raddr (w_out_addr),
      .o_rdata (w_dict_raw)
   );

   assign w_dict_valid = w_dict_raw[STATE_W];
   assign w_dict_state = w_dict_raw[STATE_W-1:0];
`else
   assign w_dict_valid = 1'b0;
   assign w_dict_state = '0;
`endif

   // Datapath latches: the character under fail-hop resolution and the next dict link.
   always_ff @(posedge CLK) begin
      if (r_fsm == S_ACCEPT && IN_VALID) begin
         r_char <= IN_CHAR;
         r_last <= IN_LAST;
      end
      if (w_dict_valid) r_dptr <= w_dict_state;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_fsm    <= S_IDLE;
         r_cur    <= '0;
         r_pos    <= '0;
         r_mvalid <= 1'b0;
         r_mid    <= '0;
         r_mpos   <= '0;
         r_done   <= 1'b0;
      end else begin
         r_mvalid <= 1'b0;
         r_done   <= 1'b0;
         case (r_fsm)
            S_IDLE: begin
               if (EN) r_fsm <= S_ACCEPT;
            end
            S_ACCEPT, S_FAIL: begin
               if (r_fsm == S_ACCEPT && !IN_VALID) begin
                  if (!EN) r_fsm <= S_IDLE;
               end else if (w_g.hit || r_cur == '0) begin
                  // Character resolved: either a goto hit or a miss at the root.
                  r_pos <= r_pos + 1'b1;
                  r_fsm <= w_after;
                  if (w_g.hit) begin
                     r_cur <= w_g.next;
                     if (w_out.valid) begin
                        r_mvalid <= 1'b1;
                        r_mid    <= w_out.id;
                        r_mpos   <= r_pos;
                        if (w_dict_valid) r_fsm <= S_REPORT;
                     end
                  end
               end else begin
                  r_cur <= w_fail_next;
                  r_fsm <= S_FAIL;
               end
            end
            S_REPORT: begin
               r_mvalid <= w_out.valid;
               r_mid    <= w_out.id;
               if (!w_dict_valid) r_fsm <= w_after;
            end
            S_DONE: begin
               r_done <= 1'b1;
               r_cur  <= '0;
               r_pos  <= '0;
               r_fsm  <= EN ? S_ACCEPT : S_IDLE;
            end
            default: r_fsm <= S_IDLE;
         endcase
      end
   end

   assign IN_READY    = (r_fsm == S_ACCEPT);
   assign MATCH_VALID = r_mvalid;
   assign MATCH_ID    = r_mid;
   assign MATCH_POS   = r_mpos;
   assign DONE        = r_done;

endmodule

// File: tb/tb_ac_stream_matcher.sv
// Bench for ac_stream_matcher: loads the he/she/his/hers automaton and checks reports against a string-search model.
module tb_ac_stream_matcher;
   import ac_pkg::*;

   localparam int CHAR_W  = 8;
   localparam int STATE_W = 6;
   localparam int PAT_W   = 4;
   localparam int POS_W   = 4;

   logic                      CLK = 1'b0;
   logic                      RST = 1'b1;
   logic                      EN = 1'b0;
   logic                      CFG_WE = 1'b0;
   logic [1:0]                CFG_SEL = '0;
   logic [STATE_W+CHAR_W-1:0] CFG_ADDR = '0;
   logic [STATE_W+PAT_W:0]    CFG_DATA = '0;
   logic                      IN_VALID = 1'b0;
   logic                      IN_READY;
   logic [CHAR_W-1:0]         IN_CHAR = '0;
   logic                      IN_LAST = 1'b0;
   logic                      MATCH_VALID;
   logic [PAT_W-1:0]          MATCH_ID;
   logic [POS_W-1:0]          MATCH_POS;
   logic                      DONE;

   always #5 CLK = ~CLK;

   ac_stream_matcher #(.CHAR_W(CHAR_W), .STATE_W(STATE_W), .PAT_W(PAT_W), .POS_W(POS_W)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .CFG_WE(CFG_WE), .CFG_SEL(CFG_SEL),
      .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .IN_CHAR(IN_CHAR), .IN_LAST(IN_LAST), .MATCH_VALID(MATCH_VALID), .MATCH_ID(MATCH_ID),
      .MATCH_POS(MATCH_POS), .DONE(DONE)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: text since the last DONE, and the ordered list of expected events.
   typedef struct { bit is_done; int id; int pos; } ev_t;
   ev_t   expq[$];
   byte   hist[$];
   int    model_pos = 0;
   string pats[4] = '{"he", "she", "his", "hers"};

   function automatic bit tail_is(input string s, input int k);
      if (k > hist.size() || k > s.len()) return 1'b0;
      for (int j = 0; j < k; j++)
         if (hist[hist.size()-k+j] != s[j]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_push(input byte c, input bit last);
      int best = 0;
      int prim = -1;
      hist.push_back(c);
      for (int k = 1; k <= 4; k++)
         for (int p = 0; p < 4; p++)
            if (tail_is(pats[p], k)) best = k;
      for (int p = 0; p < 4; p++)
         if (pats[p].len() == best && tail_is(pats[p], best)) prim = p;
      if (prim >= 0) begin
         expq.push_back('{1'b0, prim, model_pos});
`ifdef AC_DICT_LINK_EN
         for (int l = best - 1; l >= 1; l--)
            for (int p = 0; p < 4; p++)
               if (pats[p].len() == l && tail_is(pats[p], l)) expq.push_back('{1'b0, p, model_pos});
`endif
      end
      model_pos = (model_pos + 1) % (1 << POS_W);
      if (last) begin
         expq.push_back('{1'b1, 0, 0});
         hist.delete();
         model_pos = 0;
      end
   endtask

   // Observation log for the literal expectations.
   int  obs_id[$];
   int  obs_pos[$];
   int  obs_cyc[$];
   int  done_n = 0;
   int  ready_low = 0;
   bit  meas = 1'b0;
   int  cyc = 0;
   ev_t mon_e;

   always @(negedge CLK) begin
      if (RST) begin
         cyc++;
         if (meas && !IN_READY) ready_low++;
         if (MATCH_VALID) begin
            obs_id.push_back(int'(MATCH_ID));
            obs_pos.push_back(int'(MATCH_POS));
            obs_cyc.push_back(cyc);
            checks++;
            if (expq.size() == 0 || expq[0].is_done) begin
               failures++;
               $display("FAIL match_unexpected actual id=%0d pos=%0d required no match", MATCH_ID, MATCH_POS);
            end else begin
               mon_e = expq.pop_front();
               if (mon_e.id != int'(MATCH_ID) || mon_e.pos != int'(MATCH_POS)) begin
                  failures++;
                  $display("FAIL match_value actual id=%0d pos=%0d required id=%0d pos=%0d",
                           MATCH_ID, MATCH_POS, mon_e.id, mon_e.pos);
               end
            end
         end
         if (DONE) begin
            done_n++;
            checks++;
            if (expq.size() == 0 || !expq[0].is_done) begin
               failures++;
               $display("FAIL done_unexpected actual DONE=1 required pending=%0d matches first", expq.size());
            end else begin
               mon_e = expq.pop_front();
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic clear_obs();
      obs_id.delete();
      obs_pos.delete();
      obs_cyc.delete();
      done_n = 0;
      ready_low = 0;
   endtask

   task automatic cfg_write(input logic [1:0] sel, input int addr, input int data);
      @(negedge CLK);
      CFG_WE = 1'b1;
      CFG_SEL = sel;
      CFG_ADDR = (STATE_W+CHAR_W)'(addr);
      CFG_DATA = (STATE_W+PAT_W+1)'(data);
      @(negedge CLK);
      CFG_WE = 1'b0;
   endtask

   task automatic send_char(input byte c, input bit last);
      int n = 0;
      @(negedge CLK);
      IN_VALID = 1'b1;
      IN_CHAR = c;
      IN_LAST = last;
      while (!IN_READY && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (!IN_READY) begin
         checks++;
         failures++;
         $display("FAIL send_ready_timeout actual ready=0 required ready=1 char=%0d", c);
         IN_VALID = 1'b0;
         return;
      end
      @(posedge CLK);
      model_push(c, last);
      #1;
      IN_VALID = 1'b0;
      IN_LAST = 1'b0;
   endtask

   task automatic send_str(input string s, input bit last_at_end);
      for (int i = 0; i < s.len(); i++) send_char(s[i], last_at_end && (i == s.len() - 1));
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (expq.size() != 0 && n < budget) begin
         @(negedge CLK);
         n++;
      end
      repeat (2) @(negedge CLK);
      chk("drain_pending_events", expq.size(), 0);
      expq.delete();
   endtask

   task automatic load_tables();
      string al = "hersiuxyz";
      string edge_ch = "hesheisrs";
      int    edge_from[9] = '{0, 1, 0, 3, 4, 1, 6, 2, 8};
      int    fail_tab[10] = '{0, 0, 0, 0, 1, 2, 0, 3, 0, 3};
      int    out_tab[10] = '{0, 0, 16, 0, 0, 17, 0, 18, 0, 19};
      int    g;
      for (int s = 0; s < 10; s++) begin
         for (int k = 0; k < al.len(); k++) begin
            g = 0;
            for (int e = 0; e < 9; e++)
               if (edge_from[e] == s && edge_ch[e] == al[k]) g = 64 | (e + 1);
            cfg_write(SEL_GOTO, (s << 8) | int'(al[k]), g);
         end
         cfg_write(SEL_FAIL, s, fail_tab[s]);
         cfg_write(SEL_OUT, s, out_tab[s]);
         cfg_write(SEL_DICT, s, (s == 5) ? (64 | 2) : 0);
      end
   endtask

   initial begin
      string alph = "hersix";
      byte   c;
      int    len;

      #2 RST = 1'b0;
      repeat (3) @(negedge CLK);
      chk("reset_in_ready", int'(IN_READY), 0);
      chk("reset_match_valid", int'(MATCH_VALID), 0);
      chk("reset_done", int'(DONE), 0);
      chk("reset_match_pos", int'(MATCH_POS), 0);
      RST = 1'b1;
      load_tables();

      // "ushers": she at 3, hers at 5, one stall cycle on the fail hop at 'r'
      clear_obs();
      EN = 1'b1;
      repeat (2) @(negedge CLK);
      meas = 1'b1;
      send_str("ushers", 1'b1);
      meas = 1'b0;
      drain(100);
`ifdef AC_DICT_LINK_EN
      chk("ushers_nmatch", obs_id.size(), 3);
      chk("ushers_m0_id", qget(obs_id, 0), 1);
      chk("ushers_m0_pos", qget(obs_pos, 0), 3);
      chk("ushers_m1_id", qget(obs_id, 1), 0);
      chk("ushers_m1_pos", qget(obs_pos, 1), 3);
      chk("ushers_m1_next_cycle", qget(obs_cyc, 1) - qget(obs_cyc, 0), 1);
      chk("ushers_m2_id", qget(obs_id, 2), 3);
      chk("ushers_m2_pos", qget(obs_pos, 2), 5);
      chk("ushers_ready_low_cycles", ready_low, 2);
`else
      chk("ushers_nmatch", obs_id.size(), 2);
      chk("ushers_m0_id", qget(obs_id, 0), 1);
      chk("ushers_m0_pos", qget(obs_pos, 0), 3);
      chk("ushers_m1_id", qget(obs_id, 1), 3);
      chk("ushers_m1_pos", qget(obs_pos, 1), 5);
      chk("ushers_ready_low_cycles", ready_low, 1);
`endif
      chk("ushers_done_count", done_n, 1);

      // "xyz": root misses only
      clear_obs();
      meas = 1'b1;
      send_str("xyz", 1'b1);
      meas = 1'b0;
      drain(100);
      chk("xyz_nmatch", obs_id.size(), 0);
      chk("xyz_ready_low_cycles", ready_low, 0);
      chk("xyz_done_count", done_n, 1);

      // ignored config write while running, then pause/resume inside "hers"
      clear_obs();
      cfg_write(SEL_GOTO, (2 << 8) | int'("r"), 0);
      send_str("he", 1'b0);
      @(negedge CLK);
      EN = 1'b0;
      repeat (5) @(negedge CLK);
      chk("pause_in_ready", int'(IN_READY), 0);
      EN = 1'b1;
      send_str("rs", 1'b1);
      drain(100);
      chk("pause_nmatch", obs_id.size(), 2);
      chk("pause_hers_id", qget(obs_id, 1), 3);
      chk("pause_hers_pos", qget(obs_pos, 1), 3);

      // asynchronous reset while a fail hop is in flight
      clear_obs();
      send_str("she", 1'b0);
      drain(50);
      send_char("r", 1'b0);
      RST = 1'b0;
      #1;
      chk("rst_fail_in_ready", int'(IN_READY), 0);
      chk("rst_fail_match_valid", int'(MATCH_VALID), 0);
      chk("rst_fail_match_id", int'(MATCH_ID), 0);
      chk("rst_fail_match_pos", int'(MATCH_POS), 0);
      chk("rst_fail_done", int'(DONE), 0);
      expq.delete();
      hist.delete();
      model_pos = 0;
      @(negedge CLK);
      RST = 1'b1;
      clear_obs();
      send_str("he", 1'b1);
      drain(100);
      chk("after_rst_nmatch", obs_id.size(), 1);
      chk("after_rst_he_id", qget(obs_id, 0), 0);
      chk("after_rst_he_pos", qget(obs_pos, 0), 1);

      // position wrap with a 4-bit counter: 17 fillers then "he" ends at 18 mod 16
      clear_obs();
      repeat (17) send_char("x", 1'b0);
      send_str("he", 1'b1);
      drain(100);
      chk("wrap_nmatch", obs_id.size(), 1);
      chk("wrap_he_pos", qget(obs_pos, 0), 2);

      // randomized strings with gaps and enable pauses
      for (int t = 0; t < 60; t++) begin
         len = $urandom_range(1, 12);
         for (int i = 0; i < len; i++) begin
            c = alph[$urandom_range(0, 5)];
            send_char(c, i == len - 1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
            if ($urandom_range(0, 15) == 0) begin
               @(negedge CLK);
               EN = 1'b0;
               repeat ($urandom_range(1, 4)) @(negedge CLK);
               EN = 1'b1;
            end
         end
      end
      drain(200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ac_stream_matcher.md
Name: ac_stream_matcher

Overview:
- Parametrised streaming Aho-Corasick matcher; next generation of the fixed byte-string TOP engine.
- Automaton tables (goto, fail, output) are loaded at run time through a config write port rather than hard-coded.
- Consumes a character stream with valid/ready handshake and emits pattern ID plus end position per match.
- Sits between the input string source and the match-collection logic.

Parameters:
- CHAR_W, 8, character width in bits.
- STATE_W, 6, automaton state index width (2^STATE_W states, state 0 = root).
- PAT_W, 4, pattern ID width.
- POS_W, 16, stream position counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- EN  in  1  engine enable; config writes are accepted only while EN=0.
- CFG_WE  in  1  table write strobe.
- CFG_SEL  in  2  table select: 0 goto, 1 fail, 2 output, 3 dict link.
- CFG_ADDR  in  STATE_W+CHAR_W  goto: {state,char}; others: state in low STATE_W bits.
- CFG_DATA  in  STATE_W+PAT_W+1  goto {hit,next}; fail {next}; output {valid,id}; dict {valid,state}; all LSB-aligned.
- IN_VALID  in  1  character valid.
- IN_READY  out  1  engine can accept a character.
- IN_CHAR  in  CHAR_W  stream character.
- IN_LAST  in  1  marks the final character of a string.
- MATCH_VALID  out  1  one-cycle match pulse.
- MATCH_ID  out  PAT_W  matched pattern ID.
- MATCH_POS  out  POS_W  0-based index of the match's last character.
- DONE  out  1  one-cycle pulse when the last character is fully resolved.

Behaviour:
- Reset: all outputs 0; FSM=S_IDLE; cur_state=0; pos=0. Tables are not reset; the host loads every entry used.
- Tables: register arrays with async read and sync write; writes are ignored when EN=1.
- FSM states: S_IDLE, S_ACCEPT, S_FAIL, S_REPORT, S_DONE.
- S_IDLE: IN_READY=0; goes to S_ACCEPT when EN=1.
- S_ACCEPT: IN_READY=1; on handshake, g=goto[cur_state][IN_CHAR].
  - If g.hit: cur_state<=g.next and the match is checked.
  - If miss and cur_state=0: stay at root.
  - If miss and cur_state!=0: latch char and last flag; cur_state<=fail[cur_state]; go to S_FAIL.
- S_FAIL: IN_READY=0; one fail hop per cycle using the latched char, same resolution rules as S_ACCEPT. Exits to S_ACCEPT on hit or when the root misses.
- Match check on entering state n: if output[n].valid, then MATCH_VALID=1 next cycle with MATCH_ID=output[n].id and MATCH_POS=pos of that character. Latency is 1 cycle after the resolving cycle.
- pos increments once per accepted character after resolution; wraps modulo 2^POS_W.
- Last character resolved (and reporting finished) -> S_DONE: DONE=1 for one cycle; cur_state<=0, pos<=0; then S_ACCEPT if EN else S_IDLE.
- EN=0 mid-stream: the in-flight character completes resolution/reporting, then S_IDLE; cur_state and pos are held (pause/resume).
- IN_VALID while IN_READY=0: held by the source; nothing is dropped.
- Table contract: fail[s] has strictly smaller depth than s, so fail chains terminate within 2^STATE_W hops.

Optional Feature:
- Macro AC_DICT_LINK_EN.
- Defined: dict-link table exists (CFG_SEL=3). After a primary output report, S_REPORT follows dict links one per cycle, emitting one MATCH_VALID per linked pattern at the same MATCH_POS. IN_READY=0 in S_REPORT.
- Undefined: no dict table, no S_REPORT; CFG_SEL=3 writes are ignored; only the reached state's own output is reported.

Decomposition:
- Package ac_pkg: FSM state enum; CFG_SEL constants (SEL_GOTO, SEL_FAIL, SEL_OUT, SEL_DICT); packed entry typedefs goto_entry_t {hit,next}, out_entry_t {valid,id}.
- One sub-module: ac_table_ram, a generic register array with sync write and async read, instantiated once per table.

Test Plan:
- Patterns he=0, she=1, his=2, hers=3 (states 0..9, fail[5]=2); stream "ushers" with IN_LAST on 's' -> MATCH(1,pos 3), MATCH(3,pos 5), DONE once. IN_READY=0 exactly one cycle at 'r' (fail hop 5->2->8).
- Same stream with AC_DICT_LINK_EN and dict[5]=2 -> additional MATCH(0,pos 3) the cycle after MATCH(1,3).
- Stream "xyz" (all root misses) -> no MATCH_VALID; IN_READY never drops; DONE after 'z'.
- Hold EN low mid-"hers" after 'h','e', raise 5 cycles later, send "rs" -> MATCH(3,pos 3). A config write while EN=1 has no effect.
- Assert RST during S_FAIL -> all outputs 0 and cur_state=0 immediately; a subsequent "he" gives MATCH(0,pos 1).
- POS_W=4, send 17 non-matching chars then "he" -> MATCH_POS wraps to (18 mod 16)=2.
